// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: access-size encodings and FSM state codes for the dmem responder
//   memSize_t : MEM_SIZE_B/H/W/RSV request size encodings (byte, half, word, reserved)
//   state_t   : IDLE, BUSY, DONE responder states
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        MEM_SIZE_B   = 2'b00,
        MEM_SIZE_H   = 2'b01,
        MEM_SIZE_W   = 2'b10,
        MEM_SIZE_RSV = 2'b11
    } memSize_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_responder_align.sv
// memLaneAlign: combinational little-endian lane steering for loads and stores
//   size        : access size (byte/half/word/reserved)
//   addrLo      : addr[1:0], selects the lanes
//   wdata       : right-justified store data
//   rword       : current contents of the addressed word
//   byteEn      : lanes touched by the access
//   wdataMerged : rword with the selected lanes replaced by store data
//   rdataExt    : selected lanes right-justified, zero-extended
//   fault       : misaligned or reserved-size access
module memLaneAlign
    import dmem_responder_pkg::*;
(
    input  memSize_t    size,
    input  logic [1:0]  addrLo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byteEn,
    output logic [31:0] wdataMerged,
    output logic [31:0] rdataExt,
    output logic        fault
);
    logic [31:0] wdataRep;
    logic [31:0] rShift;

    always_comb begin
        fault = (size == MEM_SIZE_RSV) || (size == MEM_SIZE_H && addrLo[0]) ||
                (size == MEM_SIZE_W && addrLo != 2'b00);
        byteEn = size == MEM_SIZE_B ? 4'b0001 << addrLo :
                 size == MEM_SIZE_H ? (addrLo[1] ? 4'b1100 : 4'b0011) :
                 size == MEM_SIZE_W ? 4'b1111 : 4'b0000;
        // replicate store data across lanes so byteEn alone picks the right copy
        wdataRep = size == MEM_SIZE_B ? {4{wdata[7:0]}} :
                   size == MEM_SIZE_H ? {2{wdata[15:0]}} : wdata;
        rShift = rword >> {addrLo, 3'b000};
        rdataExt = size == MEM_SIZE_B ? {24'd0, rShift[7:0]} :
                   size == MEM_SIZE_H ? {16'd0, rShift[15:0]} : rword;
        for (int i = 0; i < 4; i++)
            wdataMerged[8*i +: 8] = byteEn[i] ? wdataRep[8*i +: 8] : rword[8*i +: 8];
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder for the MEM-stage request interface
//   clk, reset_x : clock (rising edge), asynchronous active-low reset
//   i_memReq     : request valid, held while o_stall=1
//   i_memWrite   : 1=store, 0=load
//   i_memSize    : 00 byte, 01 half, 10 word, 11 reserved
//   i_addr       : byte address (wraps modulo DEPTH*4)
//   i_wdata      : right-justified store data
//   o_rdata      : right-justified zero-extended load data, held until next load
//   o_rvalid     : one-cycle pulse when a load completes
//   o_stall      : pipeline must hold the MEM stage
//   o_fault      : misaligned/reserved request rejected (combinational)
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        i_memReq,
    input  logic        i_memWrite,
    input  logic [1:0]  i_memSize,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
    output logic        o_stall,
    output logic        o_fault
);
    localparam int AW = $clog2(DEPTH);

    state_t      state, nextState;
    logic [3:0]  counter;
    logic        capWrite;
    memSize_t    capSize;
    logic [31:0] capAddr;
    logic [31:0] capWdata;
    logic [31:0] mem [DEPTH];
    logic [AW-1:0] wordIdx;
    logic [31:0] rword;
    logic [3:0]  byteEn;
    logic [31:0] wdataMerged;
    logic [31:0] rdataExt;
    logic        alignFault;
    logic        accept;

    // the aligner checks the live request in IDLE and serves the captured one afterwards
    memLaneAlign uAlign (
        .size        (state == IDLE ? memSize_t'(i_memSize) : capSize),
        .addrLo      (state == IDLE ? i_addr[1:0] : capAddr[1:0]),
        .wdata       (capWdata),
        .rword       (rword),
        .byteEn      (byteEn),
        .wdataMerged (wdataMerged),
        .rdataExt    (rdataExt),
        .fault       (alignFault)
    );

    assign wordIdx = AW'(capAddr >> 2);
    assign rword   = mem[wordIdx];

    always_comb begin
        accept    = state == IDLE && i_memReq && !alignFault;
        nextState = state == IDLE ? (accept ? (LATENCY == 1 ? DONE : BUSY) : IDLE) :
                    state == BUSY ? (counter == 4'd1 ? DONE : BUSY) : IDLE;
        o_stall   = reset_x && (accept || state == BUSY);
        o_fault   = reset_x && state == IDLE && i_memReq && alignFault;
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state    <= IDLE;
            counter  <= 4'd0;
            capWrite <= 1'b0;
            capSize  <= MEM_SIZE_B;
            capAddr  <= 32'd0;
            capWdata <= 32'd0;
            o_rdata  <= 32'd0;
            o_rvalid <= 1'b0;
        end else begin
            state    <= nextState;
            o_rvalid <= state == DONE && !capWrite;
            if (accept) begin
                counter  <= 4'(LATENCY - 1);
                capWrite <= i_memWrite;
                capSize  <= memSize_t'(i_memSize);
                capAddr  <= i_addr;
                capWdata <= i_wdata;
            end else if (state == BUSY) begin
                counter <= counter - 4'd1;
            end
            if (state == DONE && !capWrite)
                o_rdata <= rdataExt;
        end
    end

    // storage is deliberately outside the reset domain; only a completed store writes it
    always_ff @(posedge clk) begin
        if (state == DONE && capWrite && |byteEn)
            mem[wordIdx] <= wdataMerged;
    end

endmodule
